// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory-side signals around mem_port_arbiter.
// slave is the arbiter's view; master is the requesters/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 32
);
  logic                 f_req;
  logic [ADDR_SIZE-1:0] f_addr;
  logic                 f_ack;
  logic                 d_req;
  logic                 d_we;
  logic [ADDR_SIZE-1:0] d_addr;
  logic [DATA_SIZE-1:0] d_wdata;
  logic                 d_ack;
  logic [DATA_SIZE-1:0] rdata;
  logic                 busy;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic                 mem_memread;
  logic                 mem_memwrite;
  logic [DATA_SIZE-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_ack, d_ack, rdata, busy, mem_addr, mem_wdata, mem_memread, mem_memwrite
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_ack, d_ack, rdata, busy, mem_addr, mem_wdata, mem_memread, mem_memwrite
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between fetch and data requesters in front of a single-port memory.
// Each access takes IDLE -> ACCESS -> DONE; rdata is the registered read result (MDR).
module mem_port_arbiter #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 32
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
  typedef enum logic {GrantFetch, GrantData} grant_e;

  state_e               state_q, state_d;
  grant_e               last_q, last_d;
  logic                 op_we_q, op_we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;
  logic                 grant_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= GrantData;  // fetch wins the first tie
      op_we_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      op_we_q <= op_we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    op_we_d    = op_we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    grant_data = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.f_req || bus.d_req) begin
          // On contention the requester that did not win last time goes next.
          if (bus.f_req && bus.d_req) grant_data = (last_q == GrantFetch);
          else                        grant_data = bus.d_req;
          if (grant_data) begin
            last_d  = GrantData;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            op_we_d = bus.d_we;
          end else begin
            last_d  = GrantFetch;
            addr_d  = bus.f_addr;
            op_we_d = 1'b0;
          end
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (!op_we_q) rdata_d = bus.mem_rdata;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign bus.mem_memread  = (state_q == StAccess) && !op_we_q;
  assign bus.mem_memwrite = (state_q == StAccess) &&  op_we_q;
  assign bus.f_ack        = (state_q == StDone) && (last_q == GrantFetch);
  assign bus.d_ack        = (state_q == StDone) && (last_q == GrantData);
  assign bus.busy         = (state_q != StIdle);
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.rdata        = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed cycle checks plus randomized two-requester traffic scored against a reference memory.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

  mem_port_arbiter #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  assign bus.mem_rdata = bus.mem_memread ? mem[bus.mem_addr] : 'z;
  always @(posedge clk) if (bus.mem_memwrite) mem[bus.mem_addr] = bus.mem_wdata;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] val;
  } dexp_t;

  logic [31:0] fq[$];
  dexp_t       dq[$];
  logic [31:0] exp_rdata;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  // Scoreboard: every ack pops the oldest expectation of that requester.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("rw_exclusive", 32'(bus.mem_memread && bus.mem_memwrite), 32'd0);
      check("ack_exclusive", 32'(bus.f_ack && bus.d_ack), 32'd0);
      if (bus.f_ack) begin
        if (fq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL fetch_unexpected_ack: got ack, expected none");
        end else begin
          exp_rdata = fq.pop_front();
          check("fetch_rdata", bus.rdata, exp_rdata);
        end
      end
      if (bus.d_ack) begin
        if (dq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL data_unexpected_ack: got ack, expected none");
        end else begin
          dexp_t e;
          e = dq.pop_front();
          if (!e.we) exp_rdata = e.val;
          check(e.we ? "store_rdata_held" : "load_rdata", bus.rdata, exp_rdata);
        end
      end
    end
  end

  task automatic fetch_proc(input int n);
    int gap;
    int to;
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom_range(0, 127));
      bus.f_addr = a;
      bus.f_req  = 1'b1;
      fq.push_back(ref_mem[a]);
      to = 0;
      do begin @(negedge clk); to++; end while (!bus.f_ack && to < 20);
      if (!bus.f_ack) begin
        n_cmp++; n_err++;
        $display("FAIL fetch_timeout: got no ack, expected ack within 20 cycles");
      end
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        bus.f_req = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    bus.f_req = 1'b0;
  endtask

  task automatic data_proc(input int n);
    int gap;
    int to;
    logic [7:0] a;
    logic [31:0] wd;
    logic we;
    for (int i = 0; i < n; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = we ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 255));
      wd = $urandom;
      bus.d_we    = we;
      bus.d_addr  = a;
      bus.d_wdata = wd;
      bus.d_req   = 1'b1;
      if (we) begin
        ref_mem[a] = wd;
        dq.push_back('{we: 1'b1, val: 32'd0});
      end else begin
        dq.push_back('{we: 1'b0, val: ref_mem[a]});
      end
      to = 0;
      do begin @(negedge clk); to++; end while (!bus.d_ack && to < 20);
      if (!bus.d_ack) begin
        n_cmp++; n_err++;
        $display("FAIL data_timeout: got no ack, expected ack within 20 cycles");
      end
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        bus.d_req = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    bus.d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8'h10]     = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;
    clear_inputs();

    // Reset values, observed while reset is held
    #12;
    check("rst_fack", 32'(bus.f_ack), 32'd0);
    check("rst_dack", 32'(bus.d_ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd_wr", 32'({bus.mem_memread, bus.mem_memwrite}), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    reset_dut();

    // Single fetch of 0x10
    bus.f_req  = 1'b1;
    bus.f_addr = 8'h10;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("fetch_memread_c%0d", k), 32'(bus.mem_memread), 32'(k == 1));
      check($sformatf("fetch_fack_c%0d", k), 32'(bus.f_ack), 32'(k == 2));
      check($sformatf("fetch_dack_c%0d", k), 32'(bus.d_ack), 32'd0);
      if (k == 1) check("fetch_addr", 32'(bus.mem_addr), 32'h10);
      if (k == 2) begin
        check("fetch_rdata", bus.rdata, 32'hDEADBEEF);
        bus.f_req = 1'b0;
      end
    end

    // Store 0x12345678 to 0x20
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h20; bus.d_wdata = 32'h12345678;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("store_memwrite_c%0d", k), 32'(bus.mem_memwrite), 32'(k == 1));
      check($sformatf("store_memread_c%0d", k), 32'(bus.mem_memread), 32'd0);
      check($sformatf("store_dack_c%0d", k), 32'(bus.d_ack), 32'(k == 2));
      if (k == 1) check("store_wdata", bus.mem_wdata, 32'h12345678);
      if (k == 2) begin
        check("store_rdata_held", bus.rdata, 32'hDEADBEEF);
        bus.d_req = 1'b0;
      end
    end
    ref_mem[8'h20] = 32'h12345678;
    check("store_mem", mem[8'h20], 32'h12345678);

    // Load back 0x20
    bus.d_req = 1'b1; bus.d_we = 1'b0;
    tick();
    check("load_memread", 32'(bus.mem_memread), 32'd1);
    tick();
    check("load_dack", 32'(bus.d_ack), 32'd1);
    check("load_rdata", bus.rdata, 32'h12345678);
    bus.d_req = 1'b0;
    tick();

    // Contention from reset: fetch, data, fetch
    reset_dut();
    bus.f_req = 1'b1; bus.f_addr = 8'h11;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h30;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("cont_fack_c%0d", k), 32'(bus.f_ack), 32'(k == 2 || k == 8));
      check($sformatf("cont_dack_c%0d", k), 32'(bus.d_ack), 32'(k == 5));
      if (k == 2 || k == 8) check($sformatf("cont_frdata_c%0d", k), bus.rdata, ref_mem[8'h11]);
      if (k == 5) check("cont_drdata", bus.rdata, ref_mem[8'h30]);
      if (k == 8) begin bus.f_req = 1'b0; bus.d_req = 1'b0; end
    end

    // Back-to-back fetches of 0, 1, 2
    bus.f_req = 1'b1; bus.f_addr = 8'd0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("b2b_fack_c%0d", k), 32'(bus.f_ack), 32'(k % 3 == 2));
      if (k % 3 == 2) begin
        check($sformatf("b2b_rdata_c%0d", k), bus.rdata, ref_mem[bus.f_addr]);
        bus.f_addr = bus.f_addr + 8'd1;
        if (k == 8) bus.f_req = 1'b0;
      end
    end

    // Async reset in the middle of a write; data equals the old word so either outcome is fine
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h40; bus.d_wdata = ref_mem[8'h40];
    tick();
    check("areset_pre_memwrite", 32'(bus.mem_memwrite), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("areset_memwrite", 32'(bus.mem_memwrite), 32'd0);
    check("areset_memread", 32'(bus.mem_memread), 32'd0);
    check("areset_acks", 32'({bus.f_ack, bus.d_ack}), 32'd0);
    check("areset_busy", 32'(bus.busy), 32'd0);
    check("areset_rdata", bus.rdata, 32'd0);
    clear_inputs();
    #10;
    rst_n = 1'b1;
    tick();

    // Idle for 10 cycles
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("idle_memread_c%0d", k), 32'(bus.mem_memread), 32'd0);
      check($sformatf("idle_memwrite_c%0d", k), 32'(bus.mem_memwrite), 32'd0);
      check($sformatf("idle_busy_c%0d", k), 32'(bus.busy), 32'd0);
    end

    // Randomized two-requester traffic
    exp_rdata = bus.rdata === 32'd0 ? 32'd0 : 32'd0;
    mon_en = 1'b1;
    fork
      fetch_proc(60);
      data_proc(60);
    join
    repeat (4) tick();
    mon_en = 1'b0;
    check("fetch_queue_drained", 32'(fq.size()), 32'd0);
    check("data_queue_drained", 32'(dq.size()), 32'd0);
    for (int i = 0; i < 256; i++) check($sformatf("final_mem_%0h", i), mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
